// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN input loader.
//   NUM_BITS  : pixels per image (1 bit each)
//   NUM_BYTES : bytes per image
//   ADDR_W    : width of the core's bit read address
//   BYTE_AW   : width of a byte slot index
package snn_pkg;
  localparam int NUM_BITS  = 784;
  localparam int NUM_BYTES = NUM_BITS / 8;
  localparam int ADDR_W    = 10;
  localparam int BYTE_AW   = 7;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    START     = 2'd1,
    WAIT_CORE = 2'd2
  } loader_state_e;
endpackage

// File: rtl/ram_input_unit.sv
// Image store: NUM_BYTES x 8 RAM, byte-wide write port and a bit-addressed,
// one-cycle-latency read port.
//   clk, rst : clock, synchronous active-high reset (read register only)
//   we, waddr, wdata : byte write port
//   raddr    : bit address; addresses >= NUM_BITS read as 0
//   q        : selected pixel, valid one cycle after raddr
module ram_input_unit
  import snn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [BYTE_AW-1:0] waddr,
  input  logic [7:0]         wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic               q
);
  logic [7:0] mem [NUM_BYTES];

  logic [7:0] rd_byte_d, rd_byte_q;
  logic [2:0] bit_sel_d, bit_sel_q;
  logic       in_range;

  assign in_range = (raddr < ADDR_W'(NUM_BITS));

  // Out-of-range reads latch a zero byte, so no separate flag is needed.
  always_comb begin
    rd_byte_d = 8'h00;
    if (in_range) rd_byte_d = mem[raddr[ADDR_W-1:3]];
    bit_sel_d = raddr[2:0];
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read beside the write gives old data on a same-byte collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_byte_q <= 8'h00;
      bit_sel_q <= 3'd0;
    end else begin
      rd_byte_q <= rd_byte_d;
      bit_sel_q <= bit_sel_d;
    end
  end

  assign q = rd_byte_q[bit_sel_q];
endmodule

// File: rtl/snn_input_loader.sv
// SNN input loader: unpacks UART bytes into the 784-pixel image, pulses start
// when the image is complete and holds off new images until the core is done.
//   clk, rst          : clock, synchronous active-high reset
//   rx_rdy, rx_data   : byte from UART receiver
//   clr_rx_rdy        : one-cycle acknowledge per accepted byte
//   addr_input_unit   : bit read address from the core
//   q_input           : pixel at that address, one cycle later
//   start             : one-cycle image-ready pulse
//   done              : core finished classification
//   busy              : image handed to core, not yet released
//   byte_cnt          : bytes captured for the current image
//   overrun           : sticky, a byte arrived while busy
module snn_input_loader
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              clr_rx_rdy,
  input  logic [ADDR_W-1:0] addr_input_unit,
  output logic              q_input,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic [6:0]        byte_cnt,
  output logic              overrun
);
  localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);

  loader_state_e state_d, state_q;
  logic [6:0]    byte_cnt_d, byte_cnt_q;
  logic          clr_rx_rdy_d, clr_rx_rdy_q;
  logic          overrun_d, overrun_q;
  logic          start_d, start_q;
  logic          busy_d, busy_q;
  logic          accept;
  logic          we;

  // A byte is taken only when no acknowledge is outstanding, so a level-held
  // rx_rdy is consumed once per acknowledge pulse.
  assign accept = rx_rdy && !clr_rx_rdy_q;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      byte_cnt_q   <= 7'd0;
      clr_rx_rdy_q <= 1'b0;
      overrun_q    <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      clr_rx_rdy_q <= clr_rx_rdy_d;
      overrun_q    <= overrun_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    overrun_d    = overrun_q;
    clr_rx_rdy_d = accept;
    we           = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          we = 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = 7'd0;
            state_d    = START;
          end else begin
            byte_cnt_d = byte_cnt_q + 7'd1;
          end
        end
      end
      START: begin
        if (accept) overrun_d = 1'b1;
        state_d = WAIT_CORE;
      end
      WAIT_CORE: begin
        if (accept) overrun_d = 1'b1;
        if (done) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Outputs are registered from the state, so start lands in the cycle after
  // the final acknowledge and busy rises together with it.
  always_comb begin
    start_d = (state_q == START);
    busy_d  = (state_q != LOAD);
  end

  assign clr_rx_rdy = clr_rx_rdy_q;
  assign byte_cnt   = byte_cnt_q;
  assign overrun    = overrun_q;
  assign start      = start_q;
  assign busy       = busy_q;

  ram_input_unit u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (byte_cnt_q),
    .wdata (rx_data),
    .raddr (addr_input_unit),
    .q     (q_input)
  );
endmodule

// File: tb/tb_snn_input_loader.sv
module tb_snn_input_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       clr_rx_rdy;
  logic [9:0] addr_input_unit = 10'd0;
  logic       q_input;
  logic       start;
  logic       done = 1'b0;
  logic       busy;
  logic [6:0] byte_cnt;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int clr_cnt = 0;
  int start_cnt = 0;
  int last_clr_cyc = 0;
  int start_cyc = 0;

  snn_input_loader dut (
    .clk             (clk),
    .rst             (rst),
    .rx_rdy          (rx_rdy),
    .rx_data         (rx_data),
    .clr_rx_rdy      (clr_rx_rdy),
    .addr_input_unit (addr_input_unit),
    .q_input         (q_input),
    .start           (start),
    .done            (done),
    .busy            (busy),
    .byte_cnt        (byte_cnt),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clr_rx_rdy) begin
      clr_cnt      <= clr_cnt + 1;
      last_clr_cyc <= cyc;
    end
    if (start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
  end

  // Stimulus helpers (no checking inside)
  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    rx_rdy  = 1'b1;
    rx_data = d;
    @(negedge clk);
    rx_rdy  = 1'b0;
  endtask

  // n bytes of pat, except byte sp which gets spv
  task automatic send_bytes(input int n, input logic [7:0] pat, input int sp, input logic [7:0] spv);
    for (int i = 0; i < n; i++) send_byte((i == sp) ? spv : pat);
  endtask

  task automatic rd(input logic [9:0] a, output logic q);
    @(negedge clk);
    addr_input_unit = a;
    @(negedge clk);
    q = q_input;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({byte_cnt, clr_rx_rdy, start, busy, overrun, q_input} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got cnt=%0d clr=%b start=%b busy=%b ovr=%b q=%b want all 0",
               byte_cnt, clr_rx_rdy, start, busy, overrun, q_input);
    end
  endtask

  task automatic test_full_load();
    int c0, s0;
    logic q;
    c0 = clr_cnt; s0 = start_cnt;
    send_bytes(10, 8'h01, -1, 8'h00);
    checks++;
    if (byte_cnt !== 7'd10) begin
      failures++; $display("FAIL full_cnt10 got %0d want 10", byte_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL full_busy_loading got %b want 0", busy);
    end
    send_bytes(88, 8'h01, -1, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (clr_cnt - c0 !== 98) begin
      failures++; $display("FAIL full_clr_pulses got %0d want 98", clr_cnt - c0);
    end
    checks++;
    if (start_cnt - s0 !== 1) begin
      failures++; $display("FAIL full_start_pulses got %0d want 1", start_cnt - s0);
    end
    checks++;
    if (start_cyc !== last_clr_cyc + 1) begin
      failures++; $display("FAIL full_start_timing got cyc %0d want %0d", start_cyc, last_clr_cyc + 1);
    end
    checks++;
    if (busy !== 1'b1 || byte_cnt !== 7'd0) begin
      failures++; $display("FAIL full_busy_cnt got busy=%b cnt=%0d want busy=1 cnt=0", busy, byte_cnt);
    end
    rd(10'd0, q);   checks++; if (q !== 1'b1) begin failures++; $display("FAIL full_rd0 got %b want 1", q); end
    rd(10'd1, q);   checks++; if (q !== 1'b0) begin failures++; $display("FAIL full_rd1 got %b want 0", q); end
    rd(10'd8, q);   checks++; if (q !== 1'b1) begin failures++; $display("FAIL full_rd8 got %b want 1", q); end
    rd(10'd776, q); checks++; if (q !== 1'b1) begin failures++; $display("FAIL full_rd776 got %b want 1", q); end
  endtask

  // Runs while the image from test_full_load is with the core.
  task automatic test_overrun();
    int c0;
    logic q;
    c0 = clr_cnt;
    checks++;
    if (overrun !== 1'b0) begin
      failures++; $display("FAIL ovr_initial got %b want 0", overrun);
    end
    send_byte(8'hFF);
    repeat (2) @(negedge clk);
    checks++;
    if (clr_cnt - c0 !== 1) begin
      failures++; $display("FAIL ovr_clr got %0d want 1", clr_cnt - c0);
    end
    checks++;
    if (overrun !== 1'b1 || byte_cnt !== 7'd0) begin
      failures++; $display("FAIL ovr_flag_cnt got ovr=%b cnt=%0d want ovr=1 cnt=0", overrun, byte_cnt);
    end
    rd(10'd1, q);
    checks++;
    if (q !== 1'b0) begin
      failures++; $display("FAIL ovr_frozen got %b want 0", q);
    end
    pulse_done();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b1) begin
      failures++; $display("FAIL ovr_done got busy=%b ovr=%b want busy=0 ovr=1", busy, overrun);
    end
  endtask

  task automatic test_boundary();
    logic q;
    send_bytes(98, 8'h00, 97, 8'h80);
    repeat (2) @(negedge clk);
    rd(10'd783, q); checks++; if (q !== 1'b1) begin failures++; $display("FAIL bnd_rd783 got %b want 1", q); end
    rd(10'd782, q); checks++; if (q !== 1'b0) begin failures++; $display("FAIL bnd_rd782 got %b want 0", q); end
    rd(10'd800, q); checks++; if (q !== 1'b0) begin failures++; $display("FAIL bnd_rd800 got %b want 0", q); end
    rd(10'd0, q);   checks++; if (q !== 1'b0) begin failures++; $display("FAIL bnd_rd0 got %b want 0", q); end
  endtask

  // Starts in WAIT_CORE (left by test_boundary); the reset also covers
  // reset-in-WAIT_CORE.
  task automatic test_simultaneous();
    int c0, s0;
    s0 = start_cnt;
    do_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (start_cnt !== s0 || busy !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL sim_reset_wait got starts=%0d busy=%b ovr=%b want starts=%0d busy=0 ovr=0",
                           start_cnt, busy, overrun, s0);
    end
    send_bytes(98, 8'h3C, -1, 8'h00);
    repeat (3) @(negedge clk);
    c0 = clr_cnt; s0 = start_cnt;
    @(negedge clk);
    done = 1'b1; rx_rdy = 1'b1; rx_data = 8'hAA;
    @(negedge clk);
    done = 1'b0; rx_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (clr_cnt - c0 !== 1 || overrun !== 1'b1 || byte_cnt !== 7'd0) begin
      failures++; $display("FAIL sim_discard got clr=%0d ovr=%b cnt=%0d want clr=1 ovr=1 cnt=0",
                           clr_cnt - c0, overrun, byte_cnt);
    end
    send_bytes(97, 8'h00, -1, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (start_cnt !== s0 || byte_cnt !== 7'd97) begin
      failures++; $display("FAIL sim_97 got starts=%0d cnt=%0d want starts=%0d cnt=97", start_cnt - s0, byte_cnt, 0);
    end
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt - s0 !== 1) begin
      failures++; $display("FAIL sim_one_start got %0d want 1", start_cnt - s0);
    end
  endtask

  task automatic test_reset_mid_load();
    int s0;
    pulse_done();
    s0 = start_cnt;
    send_bytes(50, 8'hFF, -1, 8'h00);
    checks++;
    if (byte_cnt !== 7'd50) begin
      failures++; $display("FAIL rml_cnt50 got %0d want 50", byte_cnt);
    end
    do_reset();
    checks++;
    if (byte_cnt !== 7'd0 || start_cnt !== s0) begin
      failures++; $display("FAIL rml_after_rst got cnt=%0d starts=%0d want cnt=0 starts=0", byte_cnt, start_cnt - s0);
    end
    send_bytes(97, 8'h00, -1, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (start_cnt !== s0) begin
      failures++; $display("FAIL rml_97_no_start got %0d want 0", start_cnt - s0);
    end
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt - s0 !== 1) begin
      failures++; $display("FAIL rml_98_start got %0d want 1", start_cnt - s0);
    end
  endtask

  // rx_rdy held high; byte k carries value k.
  task automatic test_back_to_back();
    int c0, s0, idx, budget;
    logic [6:0] cnt_at_97;
    logic q;
    pulse_done();
    repeat (2) @(negedge clk);
    c0 = clr_cnt; s0 = start_cnt;
    idx = 0; budget = 0; cnt_at_97 = 7'd0;
    @(negedge clk);
    rx_rdy = 1'b1; rx_data = 8'd0;
    while (idx < 98 && budget < 1000) begin
      @(negedge clk);
      budget++;
      if (clr_rx_rdy) begin
        idx++;
        rx_data = 8'(idx);
        if (idx == 97) cnt_at_97 = byte_cnt;
      end
    end
    rx_rdy = 1'b0;
    checks++;
    if (idx != 98) begin
      failures++; $display("FAIL b2b_timeout got %0d acks want 98", idx);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (clr_cnt - c0 !== 98 || start_cnt - s0 !== 1) begin
      failures++; $display("FAIL b2b_pulses got clr=%0d starts=%0d want clr=98 starts=1", clr_cnt - c0, start_cnt - s0);
    end
    checks++;
    if (cnt_at_97 !== 7'd97) begin
      failures++; $display("FAIL b2b_cnt97 got %0d want 97", cnt_at_97);
    end
    checks++;
    if (start_cyc !== last_clr_cyc + 1) begin
      failures++; $display("FAIL b2b_start_timing got %0d want %0d", start_cyc, last_clr_cyc + 1);
    end
    rd(10'd40, q);  checks++; if (q !== 1'b1) begin failures++; $display("FAIL b2b_rd40 got %b want 1", q); end
    rd(10'd41, q);  checks++; if (q !== 1'b0) begin failures++; $display("FAIL b2b_rd41 got %b want 0", q); end
    rd(10'd42, q);  checks++; if (q !== 1'b1) begin failures++; $display("FAIL b2b_rd42 got %b want 1", q); end
    rd(10'd776, q); checks++; if (q !== 1'b1) begin failures++; $display("FAIL b2b_rd776 got %b want 1", q); end
    rd(10'd777, q); checks++; if (q !== 1'b0) begin failures++; $display("FAIL b2b_rd777 got %b want 0", q); end
    rd(10'd781, q); checks++; if (q !== 1'b1) begin failures++; $display("FAIL b2b_rd781 got %b want 1", q); end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_overrun();
    test_boundary();
    test_simultaneous();
    test_reset_mid_load();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
